// File: rtl/mcu_bus_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_decoder_if
// Description : Bundles the MCU byte-bus pins and the PSRAM write-request
//               handshake seen by mcu_bus_decoder.
//               The decoder takes the slave modport: it listens to the MCU bus
//               and offers write requests to the consumer. The environment
//               (MCU pins plus PSRAM write path) takes the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mcu_bus_decoder_if #(
  parameter int ADDRESS_WIDTH = 23
);

  // MCU side: asynchronous strobe, byte value and command/data flag
  logic                     mcu_bus_clock;
  logic [7:0]               mcu_bus;
  logic                     mcu_bus_command_data;

  // PSRAM write-request side: valid/ready handshake on the FIFO head
  logic                     write_valid;
  logic                     write_ready;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [7:0]               write_data;

  // Status
  logic                     error;
  logic                     busy;

  modport slave (
    input  mcu_bus_clock,
    input  mcu_bus,
    input  mcu_bus_command_data,
    input  write_ready,
    output write_valid,
    output write_address,
    output write_data,
    output error,
    output busy
  );

  modport master (
    output mcu_bus_clock,
    output mcu_bus,
    output mcu_bus_command_data,
    output write_ready,
    input  write_valid,
    input  write_address,
    input  write_data,
    input  error,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/mcu_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_decoder
// Description : Samples the 8-bit MCU bus into the system_clock domain,
//               decodes the command/data byte stream into addressed byte
//               writes and queues them in a first-word-fall-through FIFO
//               for the PSRAM write path.
//               ADDRESS_WIDTH must be at least 17; FIFO_DEPTH must be a
//               power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_bus_decoder #(
  parameter int ADDRESS_WIDTH = 23,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic             system_clock,
  input  logic             reset,
  mcu_bus_decoder_if.slave bus
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_HI_W  = ADDRESS_WIDTH - 16;

  localparam logic [c_PTR_W:0]         c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]         c_PTR_ONE  = {{c_PTR_W{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR2  = 3'd1,
    S_ADDR1  = 3'd2,
    S_ADDR0  = 3'd3,
    S_STREAM = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and strobe edge detect
  // --------------------------------------------------------------------------
  logic       r_strobe_s1, r_strobe_s2, r_strobe_s3;
  logic [7:0] r_bus_s1, r_bus_s2;
  logic       r_flag_s1, r_flag_s2;
  logic       w_strobe;

  // Two flops per MCU signal; a third strobe flop keeps history for the edge
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_strobe_s1 <= 1'b0;
      r_strobe_s2 <= 1'b0;
      r_strobe_s3 <= 1'b0;
      r_bus_s1    <= 8'h00;
      r_bus_s2    <= 8'h00;
      r_flag_s1   <= 1'b0;
      r_flag_s2   <= 1'b0;
    end else begin
      r_strobe_s1 <= bus.mcu_bus_clock;
      r_strobe_s2 <= r_strobe_s1;
      r_strobe_s3 <= r_strobe_s2;
      r_bus_s1    <= bus.mcu_bus;
      r_bus_s2    <= r_bus_s1;
      r_flag_s1   <= bus.mcu_bus_command_data;
      r_flag_s2   <= r_flag_s1;
    end
  end

  // The MCU holds byte and flag steady around the strobe, so the s2 copies
  // are settled when the rising edge reaches s2.
  assign w_strobe = r_strobe_s2 & ~r_strobe_s3;

  // --------------------------------------------------------------------------
  // Upper address byte: keep only the bits that exist in the address
  // --------------------------------------------------------------------------
  logic [c_HI_W-1:0] w_byte_hi;

  generate
    if (c_HI_W <= 8) begin : g_hi_narrow
      assign w_byte_hi = r_bus_s2[c_HI_W-1:0];
    end else begin : g_hi_wide
      assign w_byte_hi = {{(c_HI_W-8){1'b0}}, r_bus_s2};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Decoder state, address and shadow registers
  // --------------------------------------------------------------------------
  state_t                   r_state, w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_address, w_address_next;
  logic [c_HI_W-1:0]        r_shadow_hi, w_shadow_hi_next;
  logic [7:0]               r_shadow_mid, w_shadow_mid_next;
  logic                     w_push_req;
  logic                     w_err_set;
  logic                     w_err_clr;

  // Decoder state register with the address and shadow bytes it owns
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_address    <= '0;
      r_shadow_hi  <= '0;
      r_shadow_mid <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_address    <= w_address_next;
      r_shadow_hi  <= w_shadow_hi_next;
      r_shadow_mid <= w_shadow_mid_next;
    end
  end

  // Byte decode: commands abort whatever is in progress; data depends on state
  always_comb begin
    w_state_next      = r_state;
    w_address_next    = r_address;
    w_shadow_hi_next  = r_shadow_hi;
    w_shadow_mid_next = r_shadow_mid;
    w_push_req        = 1'b0;
    w_err_set         = 1'b0;
    w_err_clr         = 1'b0;

    if (w_strobe) begin
      if (r_flag_s2) begin
        case (r_bus_s2)
          8'h00: w_state_next = S_IDLE;
          8'h01: w_state_next = S_ADDR2;
          8'h02: w_state_next = S_STREAM;
          8'h03: begin
            w_err_clr    = 1'b1;
            w_state_next = S_IDLE;
          end
          default: begin
            w_err_set    = 1'b1;
            w_state_next = S_IDLE;
          end
        endcase
      end else begin
        case (r_state)
          S_ADDR2: begin
            w_shadow_hi_next = w_byte_hi;
            w_state_next     = S_ADDR1;
          end
          S_ADDR1: begin
            w_shadow_mid_next = r_bus_s2;
            w_state_next      = S_ADDR0;
          end
          S_ADDR0: begin
            // The address register only changes once all three bytes arrived,
            // so an aborted sequence leaves the previous address intact.
            w_address_next = {r_shadow_hi, r_shadow_mid, r_bus_s2};
            w_state_next   = S_IDLE;
          end
          S_STREAM: begin
            // Advance even if the FIFO drops the byte, keeping later bytes
            // aligned with the MCU's notion of the address.
            w_push_req     = 1'b1;
            w_address_next = r_address + c_ADDR_ONE;
          end
          default: begin
            w_err_set    = 1'b1;
            w_state_next = S_IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write request FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [7:0]               r_mem_data [FIFO_DEPTH];
  logic [c_PTR_W:0]         r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]         w_count, w_count_next;
  logic                     w_empty, w_full;
  logic                     w_pop, w_push, w_drop;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == c_DEPTH);
  assign w_pop   = ~w_empty & bus.write_ready;
  // A pop in the same cycle frees the slot the push needs
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & ~w_push;

  // Occupancy after this edge, used for the registered busy flag
  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop) begin
      w_count_next = w_count + c_PTR_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - c_PTR_ONE;
    end
  end

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are masked at the output while empty
  always_ff @(posedge system_clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[c_PTR_W-1:0]] <= r_address;
      r_mem_data[r_wr_ptr[c_PTR_W-1:0]] <= r_bus_s2;
    end
  end

  // --------------------------------------------------------------------------
  // Status flags
  // --------------------------------------------------------------------------
  logic r_error;
  logic r_busy;

  // Sticky error; CLEAR_ERROR has priority over any set on the same strobe
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_err_clr) begin
      r_error <= 1'b0;
    end else if (w_err_set || w_drop) begin
      r_error <= 1'b1;
    end
  end

  // Busy reflects the state and occupancy that this edge establishes
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE) || (w_count_next != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.write_valid   = ~w_empty;
  assign bus.write_address = w_empty ? '0 : r_mem_addr[r_rd_ptr[c_PTR_W-1:0]];
  assign bus.write_data    = w_empty ? 8'h00 : r_mem_data[r_rd_ptr[c_PTR_W-1:0]];
  assign bus.error         = r_error;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_bus_decoder
// Description : Self-checking bench for mcu_bus_decoder. A byte-level model of
//               the command protocol predicts the write requests and the error
//               flag; a monitor records every pop seen on the write handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_bus_decoder;

  localparam int AW    = 23;
  localparam int DEPTH = 8;

  typedef logic [AW+7:0] entry_t;

  logic system_clock = 1'b0;
  logic reset;

  always #5 system_clock = ~system_clock;

  mcu_bus_decoder_if #(.ADDRESS_WIDTH(AW)) bus ();

  mcu_bus_decoder #(
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus)
  );

  int n_checks;
  int n_fail;

  entry_t exp_q[$];
  entry_t obs_q[$];

  // Reference model: protocol-level view of the decoder
  int m_addr;
  bit m_collect;
  bit m_stream;
  bit m_err;
  int m_abytes[$];

  function automatic entry_t mk(int a, int b);
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    return {av[AW-1:0], bv[7:0]};
  endfunction

  function automatic void model_reset();
    m_addr    = 0;
    m_collect = 0;
    m_stream  = 0;
    m_err     = 0;
    m_abytes.delete();
  endfunction

  function automatic void model_cmd(int c);
    m_collect = (c == 1);
    if (c == 1) m_abytes.delete();
    m_stream = (c == 2);
    if (c == 3) m_err = 0;
    else if (c > 3) m_err = 1;
  endfunction

  function automatic void model_data(int b);
    if (m_collect) begin
      m_abytes.push_back(b);
      if (m_abytes.size() == 3) begin
        m_addr    = ((m_abytes[0] << 16) | (m_abytes[1] << 8) | m_abytes[2]) % (1 << AW);
        m_collect = 0;
      end
    end else if (m_stream) begin
      if (exp_q.size() - obs_q.size() < DEPTH) exp_q.push_back(mk(m_addr, b));
      else m_err = 1;
      m_addr = (m_addr + 1) % (1 << AW);
    end else begin
      m_err = 1;
    end
  endfunction

  function automatic bit model_busy();
    return m_collect || m_stream || (exp_q.size() != obs_q.size());
  endfunction

  // Record every accepted request
  always @(negedge system_clock) begin
    if (!reset && bus.write_valid && bus.write_ready)
      obs_q.push_back({bus.write_address, bus.write_data});
  end

  // Hang guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, got=timeout exp=finish");
    $fatal(1);
  end

  // One MCU byte transfer obeying the setup/hold/strobe-width contract
  task automatic mcu_send(input bit flag, input int b);
    logic [7:0] bv;
    logic [31:0] bw;
    bw = b;
    bv = bw[7:0];
    if (flag) model_cmd(b & 255);
    else model_data(b & 255);
    @(posedge system_clock); #1;
    bus.mcu_bus = bv;
    bus.mcu_bus_command_data = flag;
    repeat (4) @(posedge system_clock);
    #1 bus.mcu_bus_clock = 1'b1;
    repeat (4) @(posedge system_clock);
    #1 bus.mcu_bus_clock = 1'b0;
    repeat (4) @(posedge system_clock);
    #1;
  endtask

  task automatic set_address(input int a);
    mcu_send(1, 1);
    mcu_send(0, (a >> 16) & 255);
    mcu_send(0, (a >> 8) & 255);
    mcu_send(0, a & 255);
  endtask

  task automatic set_ready(input bit r);
    @(posedge system_clock); #1;
    bus.write_ready = r;
    repeat (12) @(posedge system_clock);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge system_clock); #1 reset = 1'b1;
    @(posedge system_clock); #1 reset = 1'b0;
    model_reset();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge system_clock);
    #1;
    n_checks++; if (bus.write_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.write_valid); end
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.write_address !== '0) begin n_fail++; $display("FAIL reset_address got=%h exp=0", bus.write_address); end
    n_checks++; if (bus.write_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.write_data); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int n;
    set_ready(1);
    set_address(32'h123456);
    mcu_send(1, 2);
    mcu_send(0, 8'hAA);
    mcu_send(0, 8'hBB);
    // Random address and burst
    set_address($urandom);
    mcu_send(1, 2);
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) mcu_send(0, $urandom_range(0, 255));
    mcu_send(1, 0);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_pop[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL basic_error got=%b exp=%b", bus.error, m_err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_wrap();
    set_address(32'h7FFFFF);
    mcu_send(1, 2);
    mcu_send(0, $urandom_range(0, 255));
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got=%0d exp=2", obs_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL wrap_error got=%b exp=0", bus.error); end
  endtask

  task automatic test_full();
    set_ready(0);
    set_address($urandom);
    mcu_send(1, 2);
    for (int i = 0; i < DEPTH; i++) mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.write_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got=%b exp=1", bus.write_valid); end
    n_checks++; if ({bus.write_address, bus.write_data} !== exp_q[0]) begin n_fail++; $display("FAIL full_head got=%h exp=%h", {bus.write_address, bus.write_data}, exp_q[0]); end
    n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL full_error_before got=%b exp=%b", bus.error, m_err); end
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL full_error_overflow got=%b exp=%b", bus.error, m_err); end
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if ({bus.write_address, bus.write_data} !== exp_q[0]) begin n_fail++; $display("FAIL full_head_stable got=%h exp=%h", {bus.write_address, bus.write_data}, exp_q[0]); end
    set_ready(1);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_drain_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_pop[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL full_after_pop got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]); end
    exp_q.delete(); obs_q.delete();
    mcu_send(1, 3);
    n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL full_error_clear got=%b exp=%b", bus.error, m_err); end
  endtask

  task automatic test_abort();
    set_address($urandom);
    mcu_send(1, 1);
    mcu_send(0, $urandom_range(0, 255));
    mcu_send(1, 2);
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL abort_pop got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]); end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL abort_error got=%b exp=0", bus.error); end
    mcu_send(1, 0);
  endtask

  task automatic test_errors();
    mcu_send(1, $urandom_range(4, 255));
    n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL err_bad_cmd got=%b exp=1", bus.error); end
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL err_idle_data got=%b exp=1", bus.error); end
    mcu_send(1, 3);
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", bus.error); end
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL err_idle_data2 got=%b exp=1", bus.error); end
    mcu_send(1, 3);
  endtask

  task automatic test_reset_mid();
    set_ready(0);
    set_address($urandom);
    mcu_send(1, 2);
    for (int i = 0; i < 3; i++) mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.write_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_before got=%b exp=1", bus.write_valid); end
    apply_reset();
    n_checks++; if (bus.write_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.write_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    mcu_send(0, $urandom_range(0, 255));
    n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL rstmid_error got=%b exp=%b", bus.error, m_err); end
    n_checks++; if (bus.write_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write got=%b exp=0", bus.write_valid); end
    mcu_send(1, 3);
    set_ready(1);
  endtask

  task automatic test_random();
    int op;
    int n;
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: set_address($urandom);
        1: begin
          mcu_send(1, 1);
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) mcu_send(0, $urandom_range(0, 255));
        end
        2: begin
          mcu_send(1, 2);
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) mcu_send(0, $urandom_range(0, 255));
        end
        3: mcu_send(1, $urandom_range(0, 7));
        4: mcu_send(0, $urandom_range(0, 255));
        default: set_ready($urandom_range(0, 1));
      endcase
      n_checks++; if (bus.error !== m_err) begin n_fail++; $display("FAIL rand_error[%0d] got=%b exp=%b", k, bus.error, m_err); end
      n_checks++; if (bus.busy !== model_busy()) begin n_fail++; $display("FAIL rand_busy[%0d] got=%b exp=%b", k, bus.busy, model_busy()); end
    end
    set_ready(1);
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_pop[%0d] got=%h exp=%h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.mcu_bus_clock        = 1'b0;
    bus.mcu_bus              = 8'h00;
    bus.mcu_bus_command_data = 1'b0;
    bus.write_ready          = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_abort();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcu_bus_decoder.md
# mcu_bus_decoder

Receives the 8-bit parallel MCU bus, sampled in the `system_clock` domain, and decodes its command/data byte stream into addressed byte writes for the PSRAM write path. It sits between the board-level MCU bus pins and the PSRAM controller's write request interface. A small FIFO absorbs MCU bursts while PSRAM is busy.

## Interface
Parameters:
- ADDRESS_WIDTH, 23, PSRAM byte address width (8 MiB)
- FIFO_DEPTH, 8, write request FIFO entries (power of two, ≥2)

Ports:
- system_clock  input  1  sole clock; every flop is on its rising edge
- reset  input  1  synchronous, active-high
- mcu_bus_clock  input  1  MCU byte strobe, asynchronous; a rising edge marks one byte
- mcu_bus  input  8  byte value
- mcu_bus_command_data  input  1  1 = command byte, 0 = data byte
- write_valid  output  1  FIFO head holds a request
- write_ready  input  1  consumer accepts the head this cycle
- write_address  output  ADDRESS_WIDTH  head address
- write_data  output  8  head byte
- error  output  1  sticky fault flag
- busy  output  1  decoder not IDLE, or FIFO not empty

## Operation
- Input sampling: `mcu_bus_clock`, `mcu_bus` and `mcu_bus_command_data` each pass through a 2-flop synchronizer (s1, s2).
  - A third flop s3 holds the previous strobe value.
  - `strobe = s2 & ~s3`.
  - On `strobe`, the byte and flag in their s2 stage are consumed.
  - MCU contract: byte and flag stable ≥3 `system_clock` periods before the strobe rises, and held ≥2 periods after it.
  - Strobe high and low phases are each ≥3 periods.
- Commands (flag = 1):
  - 0x00 NOP: go to IDLE.
  - 0x01 SET_ADDRESS: go to ADDR2.
  - 0x02 WRITE: go to STREAM.
  - 0x03 CLEAR_ERROR: clear `error`, go to IDLE.
  - Any other value: set `error`, go to IDLE.
  - A command byte is accepted in every state and aborts the operation in progress. In particular, a partial SET_ADDRESS is discarded and the address register keeps its prior value.
- Data (flag = 0), by state:
  - ADDR2: shadow[ADDRESS_WIDTH-1:16] = byte (excess upper bits ignored); go to ADDR1.
  - ADDR1: shadow[15:8] = byte; go to ADDR0.
  - ADDR0: address register = {shadow high, shadow mid, byte}; go to IDLE.
  - STREAM: push {address, byte} into the FIFO, then address = (address + 1) mod 2^ADDRESS_WIDTH. Stay in STREAM.
  - IDLE: byte dropped; `error` set.
- FIFO full on a STREAM push:
  - A push is accepted if the FIFO is not full, or if a pop (`write_valid & write_ready`) happens in the same cycle.
  - Otherwise the byte is dropped and `error` is set. The address still increments, so later bytes land at their intended locations.
- Output handshake:
  - A pop occurs when `write_valid & write_ready`.
  - While `write_valid & ~write_ready`, `write_address` and `write_data` hold stable.
  - `write_valid` never drops without a pop, except on reset.
- `error` is set by the events listed above. It is cleared only by CLEAR_ERROR or reset. If the same strobe both sets and clears it, clearing wins (CLEAR_ERROR is the only command involved).

## Timing
- Reset values:
  - `write_valid`, `error`, `busy` = 0.
  - `write_address`, `write_data` = 0.
  - Address register, shadow register and synchronizer flops = 0.
  - State = IDLE, FIFO empty.
- Reset applied mid-burst empties the FIFO and discards partial address bytes. A strobe that is in flight during reset is lost.
- Latency (edge 0 = first edge at which s1 samples the strobe high):
  - `strobe` is asserted after edge 1.
  - The state / address update and the FIFO write occur at edge 2.
  - `write_valid` is high after edge 2 when the FIFO was empty. The FIFO is first-word-fall-through, with no extra output register.
- `busy` is registered. It reflects state and FIFO occupancy after each edge.
- Throughput: one byte per strobe, bounded by the MCU contract (≥6 `system_clock` periods per byte). The FIFO drains one entry per cycle while `write_ready` = 1.
- Address wrap: 2^ADDRESS_WIDTH−1 + 1 → 0, with no error.

## Test plan
- Reset, then send cmd 0x01 and data 0x12, 0x34, 0x56; then cmd 0x02 and data 0xAA, 0xBB, with `write_ready` = 1 → two pops: (0x123456, 0xAA), then (0x123457, 0xBB). `error` = 0; `busy` = 0 at the end.
- Set the address to 0x7FFFFF, send WRITE, then data 0x01, 0x02 → pops at 0x7FFFFF, then 0x000000.
- Hold `write_ready` = 0 and stream 10 bytes with FIFO_DEPTH = 8 → 8 entries held, with the head stable. `error` = 1 after byte 9. Raising `write_ready` yields 8 pops in order (addresses base..base+7). A further byte lands at base+10.
- Send cmd 0x01 and data 0x11, then cmd 0x02 and data 0x55 → the write goes to the previous address; the partial address is discarded and `error` = 0.
- Send cmd 0x7F → `error` = 1. Send a data byte in IDLE → `error` stays 1. Send cmd 0x03 → `error` = 0.
- Assert `reset` for one cycle while the FIFO holds 3 entries in STREAM → after the reset edge, `write_valid` = 0 and `busy` = 0. A following data byte with no new command sets `error`.
